bp_be_irf_cfg_access: RTL and testbench
=======================================

Name: bp_be_irf_cfg_access

Overview:
- Initiator side of the integer-register-file configuration access path. It accepts debug/config read and write requests over a valid/ready link and sequences them into single-cycle irf strobes on the cfg bus.
- For reads, it captures the synchronous regfile read data (cfg_data) one cycle after the strobe and returns it on a held response channel.
- It sits between the cfg-bus decode logic and the backend regfile. It drives the irf_w_v, irf_r_v, irf_addr and irf_data fields and consumes the regfile's cfg_data output.

Parameters:
- reg_addr_width_p, 5, register index width.
- dword_width_p, 64, register data width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- freeze_i  in  1  core frozen. Requests are accepted only while high.
- req_v_i  in  1  request valid
- req_ready_o  out  1  request ready. Handshake on req_v_i & req_ready_o.
- req_w_i  in  1  1 = write, 0 = read
- req_addr_i  in  reg_addr_width_p  register index
- req_data_i  in  dword_width_p  write data (ignored for reads)
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i
- resp_data_o  out  dword_width_p  read data; 0 for writes
- irf_w_v_o  out  1  cfg-bus regfile write strobe
- irf_r_v_o  out  1  cfg-bus regfile read strobe
- irf_addr_o  out  reg_addr_width_p  cfg-bus regfile index
- irf_data_o  out  dword_width_p  cfg-bus regfile write data
- irf_rdata_i  in  dword_width_p  regfile cfg_data. Valid only in the cycle after irf_r_v_o.

Behaviour:
- FSM states:
  - e_ready
  - e_issue
  - e_capture
  - e_resp
- Reset state is e_ready. At reset all outputs are 0, and req_ready_o = freeze_i.
- Accept:
  - req_ready_o = (state == e_ready) & freeze_i.
  - On handshake, register req_w, req_addr and req_data, then go to e_issue.
  - No request is accepted in any other state.
- e_issue, lasts exactly one cycle:
  - irf_addr_o and irf_data_o are driven from the registered values in every state; the strobes are 0 outside e_issue.
  - Write, addr != 0: irf_w_v_o = 1, then go to e_resp with resp_data = 0.
  - Read, addr != 0: irf_r_v_o = 1, then go to e_capture.
  - Addr == 0: no strobe. A write goes to e_resp with data 0; a read goes to e_resp with data 0. x0 is never written or read through this path.
- e_capture, lasts exactly one cycle:
  - resp_data register <= irf_rdata_i, then go to e_resp.
  - The sample is taken in exactly this cycle. The regfile's read port resumes pipeline reads afterwards, so its output changes.
- e_resp:
  - resp_v_o = 1.
  - resp_data_o is stable while resp_v_o = 1 and resp_ready_i = 0.
  - On resp_ready_i, go to e_ready. A new request may be accepted the following cycle; there is no same-cycle resp/accept overlap.
- Latency, with handshake at cycle T:
  - Write: strobe at T+1, resp_v at T+2.
  - Read: strobe at T+1, capture at T+2, resp_v at T+3.
  - x0 access: resp_v at T+2.
- Strobes:
  - At most one of irf_w_v_o and irf_r_v_o is high in any cycle.
  - Each strobe is high for exactly one cycle per request.
- freeze_i deassert after acceptance: the operation completes normally. Write conflicts are resolved by the regfile's cfg-write priority. freeze_i gates acceptance only.
- Reset mid-operation: return to e_ready next cycle. Any pending response is dropped, and strobes are 0 in the reset cycle.
- resp_ready_i high outside e_resp has no effect.

Decomposition:
- Shared package: the state enum bp_be_irf_cfg_state_e (2 bits) and a request struct macro (w, addr, data) sized from reg_addr_width_p and dword_width_p.
- The cfg-bus struct fields are assigned by the instantiating cfg-bus logic.
- Single module, no sub-module. The request and response holding registers use bsg_dff_reset_en.

Test Plan:
1. freeze_i = 1. Write x5 = 64'hDEAD_BEEF_0123_4567 accepted at T → at T+1 irf_w_v_o = 1, irf_addr_o = 5, irf_data_o = that value. At T+2 resp_v_o = 1, resp_data_o = 0.
2. Read x5 with irf_rdata_i = 64'hDEAD_BEEF_0123_4567 driven only at T+2 → irf_r_v_o = 1 at T+1 only; resp_data_o = 64'hDEAD_BEEF_0123_4567 from T+3. Change irf_rdata_i at T+3 → resp_data_o unchanged.
3. Write x0 = 64'hFFFF, then read x0 → no irf strobes in any cycle. Both responses arrive at T+2 with data 0.
4. Hold resp_ready_i = 0 for 4 cycles during a read response → resp_v_o and resp_data_o stay stable, req_ready_o = 0, and req_v_i is ignored. Release → response consumed, req_ready_o = 1 the next cycle.
5. freeze_i = 0 with req_v_i = 1 for 5 cycles → req_ready_o = 0 and no strobes. Raise freeze_i → accepted that cycle, strobe the next cycle.
6. Assert reset_i at T+2 of a read (state e_capture) → next cycle state is e_ready, resp_v_o = 0, and no response is ever produced for that request.

Source files
------------

// File: rtl/bp_be_irf_cfg_access_pkg.sv
// Shared types for the irf cfg-access initiator: FSM state encoding and the
// request record macro, sized by the instantiating module's parameters.
`ifndef BP_BE_IRF_CFG_ACCESS_PKG_SV
`define BP_BE_IRF_CFG_ACCESS_PKG_SV

`define DECLARE_BP_BE_IRF_CFG_REQ_S(addr_w, data_w) \
    typedef struct packed {                          \
        logic              w;                        \
        logic [addr_w-1:0] addr;                     \
        logic [data_w-1:0] data;                     \
    } bp_be_irf_cfg_req_s

package bp_be_irf_cfg_access_pkg;

    localparam int irf_reg_addr_width_gp = 5;
    localparam int irf_dword_width_gp    = 64;

    typedef enum logic [1:0] {
        e_ready   = 2'd0,
        e_issue   = 2'd1,
        e_capture = 2'd2,
        e_resp    = 2'd3
    } bp_be_irf_cfg_state_e;

endpackage

`endif

// File: rtl/bsg_dff_reset_en.sv
// Enabled flop with synchronous active-high reset to a constant value.
module bsg_dff_reset_en #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_data <= reset_val_p;
        else if (en_i)
            r_data <= data_i;
    end

    assign data_o = r_data;

endmodule

// File: rtl/bp_be_irf_cfg_access.sv
// Sequences debug/config irf requests into single-cycle cfg-bus strobes and
// returns captured read data on a held response channel.
module bp_be_irf_cfg_access
    import bp_be_irf_cfg_access_pkg::*;
#(
    parameter int reg_addr_width_p = irf_reg_addr_width_gp,
    parameter int dword_width_p    = irf_dword_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        freeze_i,

    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic                        req_w_i,
    input  logic [reg_addr_width_p-1:0] req_addr_i,
    input  logic [dword_width_p-1:0]    req_data_i,

    output logic                        resp_v_o,
    input  logic                        resp_ready_i,
    output logic [dword_width_p-1:0]    resp_data_o,

    output logic                        irf_w_v_o,
    output logic                        irf_r_v_o,
    output logic [reg_addr_width_p-1:0] irf_addr_o,
    output logic [dword_width_p-1:0]    irf_data_o,
    input  logic [dword_width_p-1:0]    irf_rdata_i
);

    `DECLARE_BP_BE_IRF_CFG_REQ_S(reg_addr_width_p, dword_width_p);

    bp_be_irf_cfg_state_e r_state, w_state_n;
    bp_be_irf_cfg_req_s   w_req_in, r_req;

    logic                     w_accept;
    logic                     w_addr_zero;
    logic                     w_irf_w_v, w_irf_r_v, w_resp_v;
    logic                     w_resp_en;
    logic [dword_width_p-1:0] w_resp_d, r_resp_data;

    assign req_ready_o = (r_state == e_ready) & freeze_i;
    assign w_accept    = req_v_i & req_ready_o;
    assign w_addr_zero = (r_req.addr == '0);

    assign w_req_in.w    = req_w_i;
    assign w_req_in.addr = req_addr_i;
    assign w_req_in.data = req_data_i;

    bsg_dff_reset_en #(
        .width_p ($bits(bp_be_irf_cfg_req_s))
    ) u_req_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_accept),
        .data_i  (w_req_in),
        .data_o  (r_req)
    );

    bsg_dff_reset_en #(
        .width_p (dword_width_p)
    ) u_resp_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_resp_en),
        .data_i  (w_resp_d),
        .data_o  (r_resp_data)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_state <= e_ready;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_irf_w_v = 1'b0;
        w_irf_r_v = 1'b0;
        w_resp_v  = 1'b0;
        w_resp_en = 1'b0;
        w_resp_d  = '0;
        case (r_state)
            e_ready: begin
                if (w_accept)
                    w_state_n = e_issue;
            end
            e_issue: begin
                // Writes and x0 accesses answer with zero; clear it here so the
                // response register never leaks a previous read's data.
                w_resp_en = 1'b1;
                if (!w_addr_zero) begin
                    w_irf_w_v = r_req.w;
                    w_irf_r_v = ~r_req.w;
                end
                w_state_n = (!w_addr_zero && !r_req.w) ? e_capture : e_resp;
            end
            e_capture: begin
                // Regfile read data is valid only in this cycle.
                w_resp_en = 1'b1;
                w_resp_d  = irf_rdata_i;
                w_state_n = e_resp;
            end
            e_resp: begin
                w_resp_v = 1'b1;
                if (resp_ready_i)
                    w_state_n = e_ready;
            end
            default: w_state_n = e_ready;
        endcase
    end

    assign irf_w_v_o   = w_irf_w_v & ~reset_i;
    assign irf_r_v_o   = w_irf_r_v & ~reset_i;
    assign resp_v_o    = w_resp_v  & ~reset_i;
    assign resp_data_o = r_resp_data;
    assign irf_addr_o  = r_req.addr;
    assign irf_data_o  = r_req.data;

endmodule

// File: tb/tb_bp_be_irf_cfg_access.sv
// Directed and randomized bench for the irf cfg-access initiator; expected
// responses come from a bench-side register array and the latency rules.
module tb_bp_be_irf_cfg_access;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        freeze_i;
    logic        req_v_i;
    logic        req_ready_o;
    logic        req_w_i;
    logic [4:0]  req_addr_i;
    logic [63:0] req_data_i;
    logic        resp_v_o;
    logic        resp_ready_i;
    logic [63:0] resp_data_o;
    logic        irf_w_v_o;
    logic        irf_r_v_o;
    logic [4:0]  irf_addr_o;
    logic [63:0] irf_data_o;
    logic [63:0] irf_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [63:0] ref_mem [32];

    always #5 clk_i = ~clk_i;

    bp_be_irf_cfg_access #(
        .reg_addr_width_p (5),
        .dword_width_p    (64)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .freeze_i     (freeze_i),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .req_w_i      (req_w_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .resp_v_o     (resp_v_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .irf_w_v_o    (irf_w_v_o),
        .irf_r_v_o    (irf_r_v_o),
        .irf_addr_o   (irf_addr_o),
        .irf_data_o   (irf_data_o),
        .irf_rdata_i  (irf_rdata_i)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input bit exp_w, input bit exp_r);
        chk({tag, "_w_v"}, 64'(irf_w_v_o), 64'(exp_w));
        chk({tag, "_r_v"}, 64'(irf_r_v_o), 64'(exp_r));
    endtask

    // One full request: optional frozen-wait cycles, handshake, strobe,
    // optional capture, held response, consume. Starts and ends at posedge+1.
    task automatic txn(input bit w, input logic [4:0] addr, input logic [63:0] data,
                       input int hold, input int frozen_wait);
        logic [63:0] exp_data;
        bit          is_rd;
        is_rd = !w && (addr != 0);
        for (int i = 0; i < frozen_wait; i++) begin
            freeze_i = 1'b0; req_v_i = 1'b1; req_w_i = w; req_addr_i = addr; req_data_i = data;
            @(negedge clk_i);
            chk("frozen_ready", 64'(req_ready_o), 64'd0);
            chk_strobes("frozen", 1'b0, 1'b0);
            next_cycle();
        end
        freeze_i = 1'b1; req_v_i = 1'b1; req_w_i = w; req_addr_i = addr; req_data_i = data;
        @(negedge clk_i);
        chk("accept_ready", 64'(req_ready_o), 64'd1);
        chk("accept_resp_v", 64'(resp_v_o), 64'd0);
        next_cycle();
        // T+1: issue; scramble request inputs and ready, none should matter
        req_v_i = $urandom_range(0, 1); req_w_i = $urandom_range(0, 1);
        req_addr_i = 5'($urandom); req_data_i = rnd64();
        resp_ready_i = $urandom_range(0, 1);
        freeze_i = $urandom_range(0, 1);
        irf_rdata_i = rnd64();
        @(negedge clk_i);
        chk_strobes("issue", w && addr != 0, is_rd);
        chk("issue_addr", 64'(irf_addr_o), 64'(addr));
        chk("issue_data", irf_data_o, data);
        chk("issue_resp_v", 64'(resp_v_o), 64'd0);
        chk("issue_ready", 64'(req_ready_o), 64'd0);
        if (w && addr != 0) ref_mem[addr] = data;
        exp_data = is_rd ? ref_mem[addr] : 64'd0;
        next_cycle();
        if (is_rd) begin
            // T+2: regfile data valid only now
            irf_rdata_i = ref_mem[addr];
            resp_ready_i = $urandom_range(0, 1);
            @(negedge clk_i);
            chk_strobes("capture", 1'b0, 1'b0);
            chk("capture_resp_v", 64'(resp_v_o), 64'd0);
            next_cycle();
            irf_rdata_i = ~ref_mem[addr];
        end
        for (int h = 0; h < hold; h++) begin
            resp_ready_i = 1'b0; req_v_i = 1'b1; req_w_i = $urandom_range(0, 1);
            req_addr_i = 5'($urandom); irf_rdata_i = rnd64();
            @(negedge clk_i);
            chk("hold_resp_v", 64'(resp_v_o), 64'd1);
            chk("hold_resp_data", resp_data_o, exp_data);
            chk("hold_ready", 64'(req_ready_o), 64'd0);
            chk_strobes("hold", 1'b0, 1'b0);
            next_cycle();
        end
        resp_ready_i = 1'b1; req_v_i = 1'b0;
        @(negedge clk_i);
        chk("resp_v", 64'(resp_v_o), 64'd1);
        chk("resp_data", resp_data_o, exp_data);
        chk("resp_ready", 64'(req_ready_o), 64'd0);
        next_cycle();
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        chk("post_resp_v", 64'(resp_v_o), 64'd0);
        chk("post_ready", 64'(req_ready_o), 64'(freeze_i));
        chk_strobes("post", 1'b0, 1'b0);
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
        reset_i = 1'b1; freeze_i = 1'b1; req_v_i = 1'b0; req_w_i = 1'b0;
        req_addr_i = '0; req_data_i = '0; resp_ready_i = 1'b0; irf_rdata_i = '0;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_resp_v", 64'(resp_v_o), 64'd0);
        chk("rst_resp_data", resp_data_o, 64'd0);
        chk("rst_addr", 64'(irf_addr_o), 64'd0);
        chk("rst_data", irf_data_o, 64'd0);
        chk_strobes("rst", 1'b0, 1'b0);
        next_cycle();
        reset_i = 1'b0;
        @(negedge clk_i);
        next_cycle();

        txn(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 0, 0);
        txn(1'b0, 5'd5, 64'd0, 0, 0);
        txn(1'b1, 5'd0, 64'hFFFF, 0, 0);
        txn(1'b0, 5'd0, 64'd0, 1, 0);
        txn(1'b1, 5'd9, 64'h0123_4567_89AB_CDEF, 0, 0);
        txn(1'b0, 5'd9, 64'd0, 4, 0);
        txn(1'b1, 5'd31, 64'hA5A5_5A5A_F00D_CAFE, 0, 5);
        txn(1'b0, 5'd31, 64'd0, 0, 0);

        // Reset while the read is in its capture cycle drops the request
        freeze_i = 1'b1; req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 5'd5;
        @(negedge clk_i);
        chk("rstmid_accept", 64'(req_ready_o), 64'd1);
        next_cycle();
        req_v_i = 1'b0;
        @(negedge clk_i);
        chk_strobes("rstmid_issue", 1'b0, 1'b1);
        next_cycle();
        reset_i = 1'b1; irf_rdata_i = ref_mem[5];
        @(negedge clk_i);
        chk_strobes("rstmid_cyc", 1'b0, 1'b0);
        chk("rstmid_resp_v", 64'(resp_v_o), 64'd0);
        next_cycle();
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_ready_i = 1'b1;
            @(negedge clk_i);
            chk("rstmid_after_resp_v", 64'(resp_v_o), 64'd0);
            chk("rstmid_after_ready", 64'(req_ready_o), 64'd1);
            next_cycle();
        end
        resp_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;  // regfile content is ours; reset does not touch it
        txn(1'b0, 5'd5, 64'd0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            txn(1'($urandom_range(0, 1)), a, rnd64(), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
